// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with Start/Ready/Valid handshake and iterative shift/multiply
//
// Purpose: registered successor to the combinational 4-flag ALU. Single-cycle
// ops (ADD, SUB, AND, OR, XOR, CMP, illegal) complete on the Start edge.
// Shifts move one bit per clock, and MUL is a DataWidth-step shift-add loop.
// Both of these run in the RUN state.
//
// Ports:
//   Clk      - system clock, rising edge
//   Reset_N  - asynchronous active-low reset
//   Start    - request, sampled only while Ready=1
//   Abort    - cancels an iterative op while in RUN (no Valid, outputs hold)
//   FuncOp   - 4-bit opcode, captured with Start
//   IFlags   - incoming {V,N,C,Z}; only C (bit 1) is used, as carry-in for ADD
//   A, B     - operands; B[CntWidth-1:0] is the shift count for shifts
//   Ready    - idle and able to accept Start
//   Valid    - one-cycle pulse marking a fresh Y/OFlags
//   Y        - registered result, holds until the next Valid
//   OFlags   - registered {V,N,C,Z}, holds until the next Valid
module alu_seq #(
  parameter int DataWidth = 16,
  parameter int FlagBits  = 4,
  parameter int CntWidth  = $clog2(DataWidth)
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [3:0]           FuncOp,
  input  logic [FlagBits-1:0]  IFlags,
  input  logic [DataWidth-1:0] A,
  input  logic [DataWidth-1:0] B,
  output logic                 Ready,
  output logic                 Valid,
  output logic [DataWidth-1:0] Y,
  output logic [FlagBits-1:0]  OFlags
);

  localparam int Msb = DataWidth - 1;

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpShl = 4'h2;
  localparam logic [3:0] OpShr = 4'h3;
  localparam logic [3:0] OpAsr = 4'h4;
  localparam logic [3:0] OpMul = 4'h5;
  localparam logic [3:0] OpAnd = 4'h6;
  localparam logic [3:0] OpOr  = 4'h7;
  localparam logic [3:0] OpXor = 4'h8;
  localparam logic [3:0] OpCmp = 4'h9;

  // One extra bit so the counter can hold DataWidth for MUL.
  localparam logic [CntWidth:0] CntOne   = {{CntWidth{1'b0}}, 1'b1};
  localparam logic [CntWidth:0] MulIters = (CntWidth + 1)'(DataWidth);

  typedef enum logic {Idle, Run} state_t;

  state_t                 state;
  logic [3:0]             op_q;
  logic [DataWidth-1:0]   sh;
  logic [2*DataWidth-1:0] acc;
  logic [DataWidth-1:0]   mcand;
  logic [CntWidth:0]      cnt;

  function automatic logic [FlagBits-1:0] pack_flags(input logic v, input logic n,
                                                     input logic c, input logic z);
    logic [FlagBits-1:0] f;
    f      = '0;
    f[3:0] = {v, n, c, z};
    return f;
  endfunction

  // Only the carry bit of IFlags feeds the datapath.
  logic unused_iflags;
  assign unused_iflags = ^{IFlags[FlagBits-1:2], IFlags[0]};

  assign Ready = (state == Idle);

  // Single-cycle datapath, evaluated on the live inputs while idle.
  logic [DataWidth:0]    add_sum, sub_sum;
  logic [DataWidth-1:0]  diff, logic_res, s_y;
  logic [FlagBits-1:0]   s_flags;
  logic                  sub_v;
  logic [CntWidth-1:0]   shamt;
  logic                  is_shift, go_run;

  assign shamt    = B[CntWidth-1:0];
  assign is_shift = (FuncOp == OpShl) || (FuncOp == OpShr) || (FuncOp == OpAsr);
  assign go_run   = (is_shift && (shamt != '0)) || (FuncOp == OpMul);

  always_comb begin
    add_sum   = {1'b0, A} + {1'b0, B} + {{DataWidth{1'b0}}, IFlags[1]};
    sub_sum   = {1'b0, A} + {1'b0, ~B} + {{DataWidth{1'b0}}, 1'b1};
    diff      = sub_sum[Msb:0];
    sub_v     = (A[Msb] != B[Msb]) && (diff[Msb] != A[Msb]);
    logic_res = '0;
    s_y       = '0;
    s_flags   = pack_flags(1'b0, 1'b0, 1'b0, 1'b1);
    case (FuncOp)
      OpAdd: begin
        s_y     = add_sum[Msb:0];
        s_flags = pack_flags((A[Msb] == B[Msb]) && (add_sum[Msb] != A[Msb]),
                             add_sum[Msb], add_sum[DataWidth], add_sum[Msb:0] == '0);
      end
      OpSub: begin
        s_y     = diff;
        s_flags = pack_flags(sub_v, diff[Msb], sub_sum[DataWidth], diff == '0);
      end
      // CMP reports the flags of A-B but passes A through.
      OpCmp: begin
        s_y     = A;
        s_flags = pack_flags(sub_v, diff[Msb], sub_sum[DataWidth], diff == '0);
      end
      OpAnd, OpOr, OpXor: begin
        if (FuncOp == OpAnd)     logic_res = A & B;
        else if (FuncOp == OpOr) logic_res = A | B;
        else                     logic_res = A ^ B;
        s_y     = logic_res;
        s_flags = pack_flags(1'b0, logic_res[Msb], 1'b0, logic_res == '0);
      end
      // Zero-count shifts finish immediately with Y=A and C=0.
      OpShl, OpShr, OpAsr, OpMul: begin
        s_y     = A;
        s_flags = pack_flags(1'b0, A[Msb], 1'b0, A == '0);
      end
      default: ;
    endcase
  end

  // One iteration of the running shift or multiply.
  logic [DataWidth-1:0]   sh_next, r_y;
  logic                   sh_out;
  logic [DataWidth:0]     mul_sum;
  logic [2*DataWidth-1:0] acc_next;
  logic [FlagBits-1:0]    r_flags;

  always_comb begin
    sh_next = sh;
    sh_out  = 1'b0;
    case (op_q)
      OpShl: begin
        sh_next = {sh[Msb-1:0], 1'b0};
        sh_out  = sh[Msb];
      end
      OpShr: begin
        sh_next = {1'b0, sh[Msb:1]};
        sh_out  = sh[0];
      end
      default: begin
        sh_next = {sh[Msb], sh[Msb:1]};
        sh_out  = sh[0];
      end
    endcase
    // acc = {partial product, remaining multiplier}; add on the multiplier LSB, then shift right.
    mul_sum  = {1'b0, acc[2*DataWidth-1:DataWidth]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {mul_sum, acc[Msb:1]};
    if (op_q == OpMul) begin
      r_y     = acc_next[Msb:0];
      r_flags = pack_flags(1'b0, acc_next[Msb], |acc_next[2*DataWidth-1:DataWidth],
                           acc_next[Msb:0] == '0);
    end else begin
      r_y     = sh_next;
      r_flags = pack_flags(1'b0, sh_next[Msb], sh_out, sh_next == '0);
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state  <= Idle;
      op_q   <= '0;
      sh     <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      Y      <= '0;
      OFlags <= '0;
      Valid  <= 1'b0;
    end else begin
      Valid <= 1'b0;
      case (state)
        // Abort is ignored here, so Start always wins in the same cycle.
        Idle: begin
          if (Start) begin
            op_q <= FuncOp;
            if (go_run) begin
              state <= Run;
              if (FuncOp == OpMul) begin
                acc   <= {{DataWidth{1'b0}}, B};
                mcand <= A;
                cnt   <= MulIters;
              end else begin
                sh  <= A;
                cnt <= {1'b0, shamt};
              end
            end else begin
              Y      <= s_y;
              OFlags <= s_flags;
              Valid  <= 1'b1;
            end
          end
        end
        Run: begin
          if (Abort) begin
            state <= Idle;
          end else begin
            cnt <= cnt - CntOne;
            if (op_q == OpMul) acc <= acc_next;
            else               sh  <= sh_next;
            // Last iteration: publish and return to idle on the same edge.
            if (cnt == CntOne) begin
              Y      <= r_y;
              OFlags <= r_flags;
              Valid  <= 1'b1;
              state  <= Idle;
            end
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq
module tb_alu_seq;

  localparam int DW = 16;
  localparam int FB = 4;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_SHL = 4'h2, OP_SHR = 4'h3,
                         OP_ASR = 4'h4, OP_MUL = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
                         OP_XOR = 4'h8, OP_CMP = 4'h9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [3:0]    funcop = '0;
  logic [FB-1:0] iflags = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          ready, valid;
  logic [DW-1:0] y;
  logic [FB-1:0] oflags;

  always #5 clk = ~clk;

  alu_seq #(.DataWidth(DW), .FlagBits(FB)) dut (
    .Clk(clk), .Reset_N(rst_n), .Start(start), .Abort(abort), .FuncOp(funcop),
    .IFlags(iflags), .A(a), .B(b), .Ready(ready), .Valid(valid), .Y(y), .OFlags(oflags)
  );

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    logic [FB-1:0] fl;
    logic [DW-1:0] ey;
    logic [FB-1:0] ef;
    int            lat;
  } vec_t;

  typedef struct {
    logic [DW-1:0] y;
    logic [FB-1:0] f;
    int            id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt[26];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every Valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got Y=%h OFlags=%h with nothing expected", y, oflags);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("y[%0d]", mon_e.id), 32'(y), 32'(mon_e.y));
        check($sformatf("flags[%0d]", mon_e.id), 32'(oflags), 32'(mon_e.f));
      end
    end
  end

  // Issue one op at a negedge; elat is the number of edges after the Start edge
  // at which Valid is registered, which is also the number of Ready-low cycles.
  task automatic run_op(input int id, input logic [3:0] op, input logic [DW-1:0] va,
                        input logic [DW-1:0] vb, input logic [FB-1:0] fl,
                        input logic [DW-1:0] ey, input logic [FB-1:0] ef,
                        input int elat, input logic ab);
    int w, lat, rlow;
    w = 0;
    while (ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) check($sformatf("ready_wait[%0d]", id), 32'(ready), 32'd1);
    funcop = op; a = va; b = vb; iflags = fl; abort = ab; start = 1'b1;
    sb.push_back('{ey, ef, id});
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    lat = 0;
    rlow = 0;
    @(negedge clk);
    while (valid !== 1'b1 && lat < 100) begin
      if (ready === 1'b0) rlow++;
      @(negedge clk);
      lat++;
    end
    check($sformatf("lat[%0d]", id), 32'(lat), 32'(elat));
    check($sformatf("ready_low[%0d]", id), 32'(rlow), 32'(elat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 4'h0, 16'h8000, 4'hC, 0};
    vt[1]  = '{OP_ADD, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 4'h3, 0};
    vt[2]  = '{OP_ADD, 16'h0001, 16'h0001, 4'h2, 16'h0003, 4'h0, 0};
    vt[3]  = '{OP_ADD, 16'h8000, 16'h8000, 4'h0, 16'h0000, 4'hB, 0};
    vt[4]  = '{OP_ADD, 16'h0002, 16'h0003, 4'hD, 16'h0005, 4'h0, 0};
    vt[5]  = '{OP_SUB, 16'h0005, 16'h0005, 4'h0, 16'h0000, 4'h3, 0};
    vt[6]  = '{OP_CMP, 16'h0003, 16'h0005, 4'h0, 16'h0003, 4'h4, 0};
    vt[7]  = '{OP_SUB, 16'h8000, 16'h0001, 4'h0, 16'h7FFF, 4'hA, 0};
    vt[8]  = '{OP_CMP, 16'h0005, 16'h0005, 4'h0, 16'h0005, 4'h3, 0};
    vt[9]  = '{OP_AND, 16'hF0F0, 16'hFF00, 4'h0, 16'hF000, 4'h4, 0};
    vt[10] = '{OP_OR,  16'h0F0F, 16'h00F0, 4'h0, 16'h0FFF, 4'h0, 0};
    vt[11] = '{OP_XOR, 16'hAAAA, 16'hAAAA, 4'h0, 16'h0000, 4'h1, 0};
    vt[12] = '{4'hA,   16'h1234, 16'h5678, 4'h2, 16'h0000, 4'h1, 0};
    vt[13] = '{4'hF,   16'hFFFF, 16'hFFFF, 4'h0, 16'h0000, 4'h1, 0};
    vt[14] = '{OP_SHL, 16'h9001, 16'h0004, 4'h0, 16'h0010, 4'h2, 4};
    vt[15] = '{OP_SHL, 16'h9001, 16'h0010, 4'h0, 16'h9001, 4'h4, 0};
    vt[16] = '{OP_SHR, 16'h8001, 16'h0001, 4'h0, 16'h4000, 4'h2, 1};
    vt[17] = '{OP_SHR, 16'h00FF, 16'h0008, 4'h0, 16'h0000, 4'h3, 8};
    vt[18] = '{OP_ASR, 16'h8000, 16'h000F, 4'h0, 16'hFFFF, 4'h4, 15};
    vt[19] = '{OP_ASR, 16'h7FF0, 16'h0004, 4'h0, 16'h07FF, 4'h0, 4};
    vt[20] = '{OP_MUL, 16'h0100, 16'h0100, 4'h0, 16'h0000, 4'h3, 16};
    vt[21] = '{OP_MUL, 16'h00FF, 16'h0003, 4'h0, 16'h02FD, 4'h0, 16};
    vt[22] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 4'h0, 16'h0001, 4'h2, 16};
    vt[23] = '{OP_SUB, 16'h0003, 16'h0005, 4'h0, 16'hFFFE, 4'h4, 0};
    vt[24] = '{OP_ASR, 16'hFFF1, 16'h0001, 4'h0, 16'hFFF8, 4'h6, 1};
    vt[25] = '{OP_CMP, 16'h8000, 16'h0001, 4'h0, 16'h8000, 4'hA, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_flags", 32'(oflags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 26; i++)
      run_op(i, vt[i].op, vt[i].va, vt[i].vb, vt[i].fl, vt[i].ey, vt[i].ef, vt[i].lat, 1'b0);

    // Start while busy is ignored and leaves Y untouched.
    run_op(100, OP_ADD, 16'h0001, 16'h0002, 4'h0, 16'h0003, 4'h0, 0, 1'b0);
    funcop = OP_ASR; a = 16'h8000; b = 16'h000F; start = 1'b1;
    sb.push_back('{16'hFFFF, 4'h4, 101});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_ready", 32'(ready), 32'd0);
    funcop = OP_ADD; a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_y_hold", 32'(y), 32'h0003);
    check("busy_no_valid", 32'(valid), 32'd0);
    begin
      int w;
      w = 0;
      while (valid !== 1'b1 && w < 40) begin
        @(negedge clk);
        w++;
      end
      check("busy_valid_seen", 32'(valid), 32'd1);
    end
    repeat (4) @(negedge clk);
    check("busy_ready_after", 32'(ready), 32'd1);

    // Abort during the 2nd RUN cycle of a MUL.
    funcop = OP_MUL; a = 16'h0100; b = 16'h0100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_y_hold", 32'(y), 32'hFFFF);
    check("abort_flags_hold", 32'(oflags), 32'h4);
    repeat (20) @(negedge clk);

    // Abort with Start in idle: Start wins and the MUL completes.
    run_op(102, OP_MUL, 16'h00FF, 16'h0003, 4'h0, 16'h02FD, 4'h0, 16, 1'b1);

    // Asynchronous reset mid-MUL.
    run_op(103, OP_ADD, 16'h7FFF, 16'h0001, 4'h0, 16'h8000, 4'hC, 0, 1'b0);
    funcop = OP_MUL; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    check("arst_flags", 32'(oflags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    run_op(104, OP_SUB, 16'h0005, 16'h0005, 4'h0, 16'h0000, 4'h3, 0, 1'b0);

    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the combinational 4-flag ALU. It adds registered results and flags, a Start/Ready/Valid handshake, and iterative multi-cycle operations: bit-serial shifts by any count and a shift-add unsigned multiply. It sits between the register file and the flags register of the A09 datapath and is sequenced by the control matrix.

Parameters:
DataWidth, 16, operand/result width; must be >= 4.
FlagBits, 4, flag vector width; bit order is {V,N,C,Z}, with Z at bit 0.
CntWidth, $clog2(DataWidth), width of the shift-count field taken from B.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset_N  input  1  asynchronous, active-low reset.
Start  input  1  request; sampled only while Ready=1.
Abort  input  1  synchronous cancel of an in-progress iterative operation.
FuncOp  input  4  operation code, captured with Start.
IFlags  input  FlagBits  incoming flags; only C (bit 1) is used, by ADD, captured with Start.
A  input  DataWidth  operand A, captured with Start.
B  input  DataWidth  operand B or shift count, captured with Start.
Ready  output  1  high when idle and able to accept Start.
Valid  output  1  one-cycle pulse; Y and OFlags are updated in the same cycle.
Y  output  DataWidth  registered result; holds until the next Valid.
OFlags  output  FlagBits  registered {V,N,C,Z}; holds until the next Valid.

Behaviour:
- Reset (Reset_N=0, asynchronous): state=IDLE, Ready=1, Valid=0, Y=0, OFlags=0, all internal counters and operand registers cleared. Reset asserted mid-operation discards it, and no Valid is produced.
- States: IDLE and RUN. Ready=1 only in IDLE. Start while Ready=0 is ignored; it is neither queued nor flagged.
- Opcodes:
  0000 ADD: {C,Y}=A+B+Cin.
  0001 SUB: {C,Y}=A+~B+1, so C=1 means no borrow.
  0010 SHL: logical shift left.
  0011 SHR: logical shift right.
  0100 ASR: arithmetic shift right.
  0101 MUL: unsigned multiply, low DataWidth bits.
  0110 AND, 0111 OR, 1000 XOR.
  1001 CMP: flags as SUB, Y=A.
  1010-1111 are illegal: Y=0, OFlags=0001, latency 1.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, CMP, illegal): Start sampled at edge t, result and flags registered at edge t, Valid=1 during the following cycle. State stays IDLE, so back-to-back Start on consecutive cycles gives consecutive Valid pulses.
- Shifts:
  - Count N=B[CntWidth-1:0]; upper bits of B are ignored.
  - N=0: single-cycle, Y=A, C=0.
  - N>=1: IDLE->RUN at edge t, one bit shifted per edge t+1..t+N, result and Valid registered at edge t+N, then RUN->IDLE.
  - Ready is low for N cycles.
  - C = the last bit shifted out.
  - ASR replicates A[DataWidth-1].
- MUL:
  - RUN for DataWidth iterations using a 2*DataWidth shift-add accumulator; Valid is registered at edge t+DataWidth.
  - Y = product[DataWidth-1:0].
  - C=1 iff product[2*DataWidth-1:DataWidth] != 0.
- Flags (every op):
  - Z = (Y==0).
  - N = Y[DataWidth-1].
  - V, ADD: A and B share a sign and Y's sign differs.
  - V, SUB/CMP: A and B signs differ and Y's sign differs from A. This uses the signed-subtract rule, not the add rule.
  - V=0 for all other ops.
  - C=0 for AND/OR/XOR.
  - CMP computes Z, N and V from the difference A-B, not from Y.
- Abort:
  - In RUN, Abort forces RUN->IDLE at the next edge. No Valid is produced, and Y/OFlags keep their previous values.
  - Abort in IDLE has no effect.
  - Abort and Start in the same IDLE cycle: Start wins.
- Final iteration: Valid and the return to IDLE (Ready=1) occur on the same edge, so a new Start may be sampled in the Valid cycle.

Test Plan:
- ADD, A=7FFF, B=0001, IFlags=0000 -> Valid 1 cycle after Start, Y=8000, OFlags=1100 (V,N).
- SUB, A=0005, B=0005 -> Y=0000, OFlags=0011 (C,Z). Then CMP, A=0003, B=0005 -> Y=0003, OFlags=0100 (N; C=0 because a borrow occurs).
- SHL, A=9001, B=0004 -> Ready low 4 cycles, Valid on the 4th edge, Y=0010, OFlags=0010. SHL with B=0010 (count 0) -> Y=A, 1-cycle latency.
- ASR, A=8000, B=000F -> Y=FFFF, OFlags=0100 after 15 cycles. A Start issued while busy is ignored, and Y is unchanged by it.
- MUL, A=0100, B=0100 -> after 16 cycles Y=0000, OFlags=0011. MUL, A=00FF, B=0003 -> Y=02FD, OFlags=0000.
- Abort at the 2nd RUN cycle of a MUL -> Ready=1 next cycle, no Valid, Y/OFlags hold. Reset_N pulsed low mid-MUL -> all outputs return to reset values immediately, without waiting for a clock edge.
